// File: rtl/imm_gen_pkg.sv
// Shared types for the immediate generator: format codes and RV32I major opcodes.
package imm_gen_pkg;

  typedef enum logic [2:0] {
    IMM_R   = 3'd0,
    IMM_I   = 3'd1,
    IMM_S   = 3'd2,
    IMM_B   = 3'd3,
    IMM_U   = 3'd4,
    IMM_J   = 3'd5,
    IMM_ILL = 3'd7
  } imm_type_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;

endpackage

// File: rtl/imm_decode.sv
// Combinational RV32I immediate decode; every format is first built as a
// signed 32-bit value and then sign-extended to XLEN.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst_code,
  output logic [XLEN-1:0] imm,
  output imm_type_e       imm_type,
  output logic            illegal
);

  logic        sign;
  logic [31:0] imm32;

  assign sign = inst_code[31];

  always_comb begin
    imm32    = '0;
    imm_type = IMM_R;
    illegal  = 1'b0;
    case (inst_code[6:0])
      OP_LOAD, OP_IMM, OP_JALR: begin
        imm32    = {{20{sign}}, inst_code[31:20]};
        imm_type = IMM_I;
      end
      OP_STORE: begin
        imm32    = {{20{sign}}, inst_code[31:25], inst_code[11:7]};
        imm_type = IMM_S;
      end
      OP_BRANCH: begin
        imm32    = {{19{sign}}, sign, inst_code[7], inst_code[30:25], inst_code[11:8], 1'b0};
        imm_type = IMM_B;
      end
      OP_LUI, OP_AUIPC: begin
        imm32    = {inst_code[31:12], 12'b0};
        imm_type = IMM_U;
      end
      OP_JAL: begin
        imm32    = {{11{sign}}, sign, inst_code[19:12], inst_code[20], inst_code[30:21], 1'b0};
        imm_type = IMM_J;
      end
      OP_OP: begin
        imm_type = IMM_R;
      end
      default: begin
        imm_type = IMM_ILL;
        illegal  = 1'b1;
      end
    endcase
  end

  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_gen_pipe.sv
// Valid/ready wrapper around imm_decode. Define IMM_GEN_PIPE_SKID_EN for a
// two-entry output+skid buffer with a registered in_ready; otherwise one register.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      inst_code,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_out,
  output imm_type_e        imm_type,
  output logic             illegal,
  output logic [TAG_W-1:0] out_tag
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    imm_type_e        ty;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } entry_t;

  localparam entry_t EMPTY = '{imm: '0, ty: IMM_R, ill: 1'b0, tag: '0};

  logic [XLEN-1:0] dec_imm;
  imm_type_e       dec_type;
  logic            dec_ill;
  entry_t          dec_e;
  entry_t          out_q;
  logic            out_valid_q;
  logic            started_q;
  logic            push;
  logic            pop;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .inst_code (inst_code),
    .imm       (dec_imm),
    .imm_type  (dec_type),
    .illegal   (dec_ill)
  );

  assign dec_e = '{imm: dec_imm, ty: dec_type, ill: dec_ill, tag: in_tag};
  assign push  = in_valid & in_ready;
  assign pop   = out_valid_q & out_ready;

  // Holds in_ready low until the first clock edge after reset is released.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) started_q <= 1'b0;
    else          started_q <= 1'b1;
  end

`ifdef IMM_GEN_PIPE_SKID_EN
  entry_t skid_q;
  logic   skid_valid_q;

  assign in_ready = started_q & ~skid_valid_q;

  // The skid slot only fills while the output register is stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q        <= EMPTY;
      out_valid_q  <= 1'b0;
      skid_q       <= EMPTY;
      skid_valid_q <= 1'b0;
    end else if (flush) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (pop) begin
      if (skid_valid_q) begin
        out_q        <= skid_q;
        skid_valid_q <= 1'b0;
      end else if (push) begin
        out_q <= dec_e;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (push) begin
      if (out_valid_q) begin
        skid_q       <= dec_e;
        skid_valid_q <= 1'b1;
      end else begin
        out_q       <= dec_e;
        out_valid_q <= 1'b1;
      end
    end
  end
`else
  assign in_ready = started_q & (out_ready | ~out_valid_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q       <= EMPTY;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (push) begin
      out_q       <= dec_e;
      out_valid_q <= 1'b1;
    end else if (pop) begin
      out_valid_q <= 1'b0;
    end
  end
`endif

  assign out_valid = out_valid_q;
  assign imm_out   = out_q.imm;
  assign imm_type  = out_q.ty;
  assign illegal   = out_q.ill;
  assign out_tag   = out_q.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: 32- and 64-bit instances share stimulus
// and are compared against a queue-based model with arithmetic immediate decode.
module tb_imm_gen_pipe;

  localparam int TAG_W = 5;
`ifdef IMM_GEN_PIPE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset_n;
  logic             flush;
  logic             in_valid;
  logic             out_ready;
  logic [31:0]      inst_code;
  logic [TAG_W-1:0] in_tag;

  logic             in_ready, out_valid, illegal;
  logic [31:0]      imm_out;
  logic [2:0]       imm_type;
  logic [TAG_W-1:0] out_tag;

  logic             in_ready64, out_valid64, illegal64;
  logic [63:0]      imm_out64;
  logic [2:0]       imm_type64;
  logic [TAG_W-1:0] out_tag64;

  typedef struct {
    logic [31:0]      inst;
    logic [TAG_W-1:0] tag;
  } ent_t;

  ent_t q[$];
  bit   started;
  int   checks;
  int   errors;

  imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .inst_code(inst_code), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .imm_out(imm_out), .imm_type(imm_type), .illegal(illegal), .out_tag(out_tag)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .inst_code(inst_code), .in_tag(in_tag), .out_valid(out_valid64), .out_ready(out_ready),
    .imm_out(imm_out64), .imm_type(imm_type64), .illegal(illegal64), .out_tag(out_tag64)
  );

  always #5 clk = ~clk;

  // Reference decode: field values weighted by position, minus the sign bit's weight.
  function automatic void model_dec(input logic [31:0] w, output longint imm,
                                    output logic [2:0] ty, output logic ill);
    imm = 0;
    ty  = 3'd0;
    ill = 1'b0;
    case (w[6:0])
      7'h03, 7'h13, 7'h67: begin
        ty  = 3'd1;
        imm = longint'(w[31:20]) - (w[31] ? 4096 : 0);
      end
      7'h23: begin
        ty  = 3'd2;
        imm = longint'(w[31:25]) * 32 + longint'(w[11:7]) - (w[31] ? 4096 : 0);
      end
      7'h63: begin
        ty  = 3'd3;
        imm = longint'(w[31]) * 4096 + longint'(w[7]) * 2048 + longint'(w[30:25]) * 32
            + longint'(w[11:8]) * 2 - (w[31] ? 8192 : 0);
      end
      7'h37, 7'h17: begin
        ty  = 3'd4;
        imm = longint'(w[31:12]) * 4096 - (w[31] ? 64'sh1_0000_0000 : 64'sh0);
      end
      7'h6F: begin
        ty  = 3'd5;
        imm = longint'(w[31]) * 1048576 + longint'(w[19:12]) * 4096 + longint'(w[20]) * 2048
            + longint'(w[30:21]) * 2 - (w[31] ? 2097152 : 0);
      end
      7'h33: ty = 3'd0;
      default: begin
        ty  = 3'd7;
        ill = 1'b1;
      end
    endcase
  endfunction

  function automatic bit model_in_ready();
    if (SKID) return started && (q.size() < 2);
    return started && (out_ready || q.size() == 0);
  endfunction

  // Advances one clock and updates the model queue from the handshake it predicts.
  task automatic step();
    bit   acc;
    bit   pop;
    ent_t e;
    acc    = in_valid && model_in_ready();
    pop    = (q.size() > 0) && out_ready;
    e.inst = inst_code;
    e.tag  = in_tag;
    @(posedge clk);
    if (!reset_n) begin
      q.delete();
      started = 1'b0;
    end else begin
      if (flush) q.delete();
      else begin
        if (pop) void'(q.pop_front());
        if (acc) q.push_back(e);
      end
      started = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n   = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    inst_code = '0;
    in_tag    = '0;
    #1 reset_n = 1'b0;
    q.delete();
    started = 1'b0;
    #1;
    checks++;
    if ({out_valid, imm_out, imm_type, illegal, out_tag, in_ready} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs32: got valid=%0b imm=%h type=%0d ill=%0b tag=%0d rdy=%0b, expected all zero",
               out_valid, imm_out, imm_type, illegal, out_tag, in_ready);
    end
    checks++;
    if ({out_valid64, imm_out64, imm_type64, illegal64, out_tag64, in_ready64} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs64: got valid=%0b imm=%h type=%0d ill=%0b tag=%0d rdy=%0b, expected all zero",
               out_valid64, imm_out64, imm_type64, illegal64, out_tag64, in_ready64);
    end
    step();
    reset_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0 || in_ready64 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_release_ready: got %0b/%0b, expected 0 before first edge", in_ready, in_ready64);
    end
    step();
    checks++;
    if (in_ready !== 1'b1 || in_ready64 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ready_after_edge: got %0b/%0b, expected 1", in_ready, in_ready64);
    end
  endtask

  task automatic test_vectors();
    logic [31:0] vi[8] = '{32'hFFF00093, 32'hFE000EE3, 32'hFF9FF06F, 32'h123452B7,
                           32'h800002B7, 32'h0000007F, 32'h00000033, 32'hFE112E23};
    logic [63:0] ve[8] = '{64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFC, 64'hFFFFFFFF_FFFFFFF8,
                           64'h00000000_12345000, 64'hFFFFFFFF_80000000, 64'h0,
                           64'h0, 64'hFFFFFFFF_FFFFFFFC};
    logic [2:0]  vt[8] = '{3'd1, 3'd3, 3'd5, 3'd4, 3'd4, 3'd7, 3'd0, 3'd2};
    logic        vl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid  = 1'b1;
      inst_code = vi[i];
      in_tag    = TAG_W'(i + 1);
      step();
      checks++;
      if (out_valid !== 1'b1 || imm_out !== ve[i][31:0] || imm_type !== vt[i] ||
          illegal !== vl[i] || out_tag !== TAG_W'(i + 1)) begin
        errors++;
        $display("[TB] FAIL vector32 %h: got valid=%0b imm=%h type=%0d ill=%0b tag=%0d, expected imm=%h type=%0d ill=%0b tag=%0d",
                 vi[i], out_valid, imm_out, imm_type, illegal, out_tag, ve[i][31:0], vt[i], vl[i], i + 1);
      end
      checks++;
      if (out_valid64 !== 1'b1 || imm_out64 !== ve[i] || imm_type64 !== vt[i] || illegal64 !== vl[i]) begin
        errors++;
        $display("[TB] FAIL vector64 %h: got valid=%0b imm=%h type=%0d ill=%0b, expected imm=%h type=%0d ill=%0b",
                 vi[i], out_valid64, imm_out64, imm_type64, illegal64, ve[i], vt[i], vl[i]);
      end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    logic [TAG_W-1:0] emitted[$];
    int               nxt;
    longint           eimm;
    logic [2:0]       ety;
    logic             eill;
    nxt       = 1;
    flush     = 1'b0;
    out_ready = 1'b0;
    for (int c = 0; c < 24 && emitted.size() < 3; c++) begin
      if (c == 5) out_ready = 1'b1;
      in_valid  = (nxt <= 3);
      in_tag    = TAG_W'(nxt);
      inst_code = 32'h0000_0013 | (32'(nxt) << 20);
      #1;
      checks++;
      if (in_ready !== model_in_ready()) begin
        errors++;
        $display("[TB] FAIL b2b_in_ready c=%0d: got %0b, expected %0b", c, in_ready, model_in_ready());
      end
      if (c == 4) begin
        checks++;
        if (in_ready !== 1'b0 || q.size() != (SKID ? 2 : 1)) begin
          errors++;
          $display("[TB] FAIL b2b_stall_full: got in_ready=%0b held=%0d, expected 0 and %0d", in_ready, q.size(), SKID ? 2 : 1);
        end
      end
      if (q.size() > 0) begin
        model_dec(q[0].inst, eimm, ety, eill);
        checks++;
        if (out_valid !== 1'b1 || out_tag !== q[0].tag || imm_out !== eimm[31:0] || imm_type !== ety) begin
          errors++;
          $display("[TB] FAIL b2b_head c=%0d: got valid=%0b tag=%0d imm=%h type=%0d, expected tag=%0d imm=%h type=%0d",
                   c, out_valid, out_tag, imm_out, imm_type, q[0].tag, eimm[31:0], ety);
        end
      end
      if (out_valid && out_ready) emitted.push_back(out_tag);
      if (in_valid && model_in_ready()) nxt++;
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (emitted.size() != 3 || emitted[0] !== 5'd1 || emitted[1] !== 5'd2 || emitted[2] !== 5'd3) begin
      errors++;
      $display("[TB] FAIL b2b_order: got %0d tags %p, expected 1,2,3", emitted.size(), emitted);
    end
    step();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      inst_code = 32'hFFF00093;
      in_tag    = TAG_W'(10 + i);
      step();
    end
    flush  = 1'b1;
    in_tag = TAG_W'(12);
    step();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_valid64 !== 1'b0 || q.size() != 0) begin
        errors++;
        $display("[TB] FAIL flush_empty c=%0d: got valid=%0b/%0b tag=%0d, expected 0", c, out_valid, out_valid64, out_tag);
      end
      step();
    end
  endtask

  task automatic test_reset_mid_stall();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      inst_code = 32'h123452B7;
      in_tag    = TAG_W'(20 + i);
      step();
    end
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    q.delete();
    started = 1'b0;
    #1;
    checks++;
    if ({out_valid, imm_out, imm_type, illegal, out_tag, in_ready} !== '0 ||
        {out_valid64, imm_out64, imm_type64, illegal64, out_tag64, in_ready64} !== '0) begin
      errors++;
      $display("[TB] FAIL midstall_reset: got valid=%0b imm=%h type=%0d ill=%0b tag=%0d rdy=%0b imm64=%h, expected all zero",
               out_valid, imm_out, imm_type, illegal, out_tag, in_ready, imm_out64);
    end
    step();
    reset_n   = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_valid64 !== 1'b0 || in_ready !== model_in_ready()) begin
        errors++;
        $display("[TB] FAIL midstall_release c=%0d: got valid=%0b/%0b rdy=%0b, expected valid 0 rdy %0b",
                 c, out_valid, out_valid64, in_ready, model_in_ready());
      end
      step();
    end
  endtask

  task automatic test_random();
    logic [6:0]  ops[10] = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F};
    logic [31:0] r;
    int          k;
    longint      eimm;
    logic [2:0]  ety;
    logic        eill;
    for (int c = 0; c < 400; c++) begin
      r         = $urandom();
      k         = $urandom_range(0, 10);
      inst_code = (k == 10) ? r : {r[31:7], ops[k]};
      in_tag    = TAG_W'($urandom());
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 31) == 0);
      #1;
      checks++;
      if (in_ready !== model_in_ready() || in_ready64 !== model_in_ready()) begin
        errors++;
        $display("[TB] FAIL rand_in_ready c=%0d: got %0b/%0b, expected %0b", c, in_ready, in_ready64, model_in_ready());
      end
      checks++;
      if (out_valid !== (q.size() > 0) || out_valid64 !== (q.size() > 0)) begin
        errors++;
        $display("[TB] FAIL rand_out_valid c=%0d: got %0b/%0b, expected %0b", c, out_valid, out_valid64, q.size() > 0);
      end
      if (q.size() > 0) begin
        model_dec(q[0].inst, eimm, ety, eill);
        checks++;
        if (imm_out !== eimm[31:0] || imm_type !== ety || illegal !== eill || out_tag !== q[0].tag) begin
          errors++;
          $display("[TB] FAIL rand_entry32 c=%0d inst=%h: got imm=%h type=%0d ill=%0b tag=%0d, expected imm=%h type=%0d ill=%0b tag=%0d",
                   c, q[0].inst, imm_out, imm_type, illegal, out_tag, eimm[31:0], ety, eill, q[0].tag);
        end
        checks++;
        if (imm_out64 !== eimm || imm_type64 !== ety || illegal64 !== eill || out_tag64 !== q[0].tag) begin
          errors++;
          $display("[TB] FAIL rand_entry64 c=%0d inst=%h: got imm=%h type=%0d ill=%0b, expected imm=%h type=%0d ill=%0b",
                   c, q[0].inst, imm_out64, imm_type64, illegal64, eimm, ety, eill);
        end
      end
      step();
    end
    flush    = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    $display("[TB] starting imm_gen_pipe bench (skid=%0b)", SKID);
    test_reset();
    test_vectors();
    test_back_to_back();
    test_flush();
    test_reset_mid_stall();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 Parameter XLEN, default 32, immediate/output width; legal values 32 and 64.
REQ-002 Parameter TAG_W, default 5, width of the sideband tag carried alongside each instruction.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 flush  input  1  synchronous discard of all held entries.
REQ-006 in_valid  input  1  inst_code/in_tag valid.
REQ-007 in_ready  output  1  block accepts input this cycle.
REQ-008 inst_code  input  32  RV32I instruction word.
REQ-009 in_tag  input  TAG_W  sideband passed through unchanged.
REQ-010 out_valid  output  1  outputs valid.
REQ-011 out_ready  input  1  consumer accepts output this cycle.
REQ-012 imm_out  output  XLEN  sign-extended immediate.
REQ-013 imm_type  output  3  format code (package enum).
REQ-014 illegal  output  1  opcode not recognised.
REQ-015 out_tag  output  TAG_W  tag of the presented entry.

Function
REQ-016 Transfer occurs on valid&ready at the rising clk edge; an accepted instruction appears on the outputs exactly 1 cycle later when no stall is present.
REQ-017 Decode by inst_code[6:0]: 0000011, 0010011, 1100111 -> I: sext(inst[31:20]).
REQ-018 0100011 -> S: sext({inst[31:25],inst[11:7]}).
REQ-019 1100011 -> B: sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}).
REQ-020 0110111, 0010111 -> U: sext({inst[31:12],12'b0}).
REQ-021 1101111 -> J: sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}).
REQ-022 0110011 -> R: imm 0, illegal 0.
REQ-023 Any other opcode -> imm 0, imm_type ILL, illegal 1.
REQ-024 Sign extension always replicates inst[31] up to bit XLEN-1.
REQ-025 Ordering is strict FIFO; no entry is dropped or duplicated except by flush.
REQ-026 out_valid, imm_out, imm_type, illegal and out_tag hold stable while out_valid=1 and out_ready=0.
REQ-027 Flush clears both entries next edge (out_valid=0); an input presented with flush is discarded; flush overrides a simultaneous transfer.
REQ-028 Simultaneous output pop and input push with one entry held: occupancy unchanged, new entry presented next cycle.

Reset
REQ-029 While reset_n=0: out_valid=0, imm_out=0, imm_type=IMM_R, illegal=0, out_tag=0, all entries empty, in_ready=0.
REQ-030 in_ready rises no earlier than the first clk edge after reset_n deasserts; reset asserted mid-stall discards all entries.

Configuration
REQ-031 Macro IMM_GEN_PIPE_SKID_EN defined: two-entry storage (output register + skid register); in_ready = !skid_full, registered, no combinational path from out_ready.
REQ-032 Macro undefined: single output register; in_ready = out_ready | !out_valid (combinational); throughput and ordering otherwise identical.

Structure
REQ-033 Package imm_gen_pkg holds imm_type_e (IMM_R=0, I=1, S=2, B=3, U=4, J=5, ILL=7) and opcode localparams.
REQ-034 Combinational decode is a sub-module imm_decode (inst_code, XLEN -> imm, type, illegal); imm_gen_pipe holds storage and handshake only.

Verification
REQ-035 0xFFF00093 (addi x1,x0,-1), out_ready=1 -> next cycle imm 0xFFFFFFFF, type I, illegal 0.
REQ-036 0xFE000EE3 (beq -4) -> 0xFFFFFFFC type B; 0xFF9FF06F (jal -8) -> 0xFFFFFFF8 type J; 0x123452B7 (lui) -> 0x12345000 type U.
REQ-037 XLEN=64, 0x800002B7 -> 0xFFFFFFFF80000000; 0x0000007F -> imm 0, illegal 1, type ILL.
REQ-038 SKID_EN, out_ready=0, 3 back-to-back inputs tags 1,2,3 -> tags 1,2 accepted, in_ready=0; out_ready=1 -> tags 1,2,3 emitted in order, outputs stable during stall.
REQ-039 Two entries held, flush=1 with in_valid=1 -> next cycle out_valid=0, no entry later emerges.
REQ-040 reset_n pulsed low mid-stall -> all outputs 0 immediately, no stale entry after release.
